// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path (and the
// future receiver that will reuse uart_baud_timer).
//   uart_state_t : frame state (IDLE, START, DATA, STOP)
//   DATA_BITS    : payload bits per frame
//   FRAME_BITS   : start + payload + stop
//   BAUD_CW      : baud counter width
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int BAUD_CW    = 24;

endpackage

// File: rtl/uart_tx_serial_if.sv
// uart_tx_serial_if: byte handshake between the console/debug UART mux and
// the serial transmitter.
//   wr   : byte-valid strobe (mux -> transmitter)
//   data : byte to send      (mux -> transmitter)
//   busy : transmitter cannot take a byte this cycle (transmitter -> mux)
// Modports: master = mux side, slave = transmitter side.
interface uart_tx_serial_if;
  import uart_pkg::*;

  logic                 wr;
  logic [DATA_BITS-1:0] data;
  logic                 busy;

  modport master (output wr, output data, input busy);
  modport slave  (input wr, input data, output busy);

endinterface

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: reload/decrement bit-period timer.
//   i_clk     : clock
//   i_reset   : synchronous active-high reset (counter to 0)
//   i_restart : load CLOCKS_PER_BAUD-1, starting a new bit period
//   o_bit_end : counter is 0 -> the current bit ends at the next edge
//   o_pre_end : counter is 1 -> one cycle before o_bit_end
// Each period spans exactly CLOCKS_PER_BAUD cycles from the restart edge, so
// restarting on every bit end gives frames with no cumulative drift.
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_bit_end,
  output logic o_pre_end
);

  localparam logic [BAUD_CW-1:0] RELOAD = BAUD_CW'(CLOCKS_PER_BAUD - 1);

  logic [BAUD_CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_restart) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - BAUD_CW'(1);
    end
  end

  assign o_bit_end = (cnt == '0);
  assign o_pre_end = (cnt == BAUD_CW'(1));

endmodule

// File: rtl/uart_tx_serial.sv
// uart_tx_serial: 8N1 serial transmitter fed by the UART mux byte strobe.
//   i_clk     : clock, rising edge
//   i_reset   : synchronous active-high reset
//   bus       : uart_tx_serial_if.slave (wr, data in; busy out)
//   i_cts_n   : clear-to-send, active low (only with UART_TX_CTS_EN)
//   o_uart_tx : serial line, idle high
// Optional feature macro: UART_TX_CTS_EN (adds i_cts_n flow control).
// All outputs are registered. busy drops for the last STOP cycle only, so a
// byte offered then starts the next frame with no idle gap.
//
// state | meaning
// IDLE  | line high, waiting for a byte
// START | start bit (line low)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (line high); last cycle may accept the next byte
module uart_tx_serial
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BAUD = 24'd868
) (
  input  logic               i_clk,
  input  logic               i_reset,
  uart_tx_serial_if.slave    bus,
`ifdef UART_TX_CTS_EN
  input  logic               i_cts_n,
`endif
  output logic               o_uart_tx
);

  if (CLOCKS_PER_BAUD < 2 || CLOCKS_PER_BAUD > 32'h00FF_FFFF) begin : g_bad_baud
    $error("uart_tx_serial: CLOCKS_PER_BAUD out of range 2..2^24-1");
  end

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_cnt;
  logic                 tx_q;
  logic                 busy_q;
  logic                 hold;
  logic                 accept;
  logic                 restart;
  logic                 bit_end;
  logic                 pre_end;

`ifdef UART_TX_CTS_EN
  // Two-flop synchroniser; no reset needed, it just tracks the pin.
  logic cts_meta;
  logic cts_sync;

  always_ff @(posedge i_clk) begin
    cts_meta <= i_cts_n;
    cts_sync <= cts_meta;
  end

  assign hold = cts_sync;
`else
  assign hold = 1'b0;
`endif

  // busy_q is 0 only in IDLE or the last STOP cycle, so this covers both
  // the idle accept and the back-to-back accept.
  assign accept  = bus.wr && !busy_q;
  assign restart = accept || (bit_end && (state == START || state == DATA));

  uart_baud_timer #(
    .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
  ) u_baud (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (restart),
    .o_bit_end (bit_end),
    .o_pre_end (pre_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= hold;
          if (accept) begin
            state  <= START;
            shreg  <= bus.data;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        STOP: begin
          if (pre_end && !hold) begin
            busy_q <= 1'b0;
          end
          if (bit_end) begin
            if (accept) begin
              state  <= START;
              shreg  <= bus.data;
              tx_q   <= 1'b0;
              busy_q <= 1'b1;
            end else begin
              state  <= IDLE;
              tx_q   <= 1'b1;
              busy_q <= hold;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_uart_tx = tx_q;
  assign bus.busy  = busy_q;

endmodule
